// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM responder: controller state encoding and
// default geometry constants.
package sram_pkg;

    // Controller state: CLEAR zeroes the array after reset, RUN serves accesses.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } sram_state_t;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 32;

endpackage : sram_pkg

// File: rtl/sram_storage.sv
// Word array for the SRAM responder: one write port and one registered read
// port. With SRAM_PARITY_EN defined, an even-parity bit is stored alongside
// every word and checked on each read; otherwise no parity bits exist and the
// mismatch flag is constant zero.
module sram_storage #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_perr
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_data_r;

    // Array write port; the array itself is not reset, it is zeroed by the
    // controller's clear sweep.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port; holds its value between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

`ifdef SRAM_PARITY_EN
    logic par_r [DEPTH];
    logic rd_perr_r;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic calc_parity(input logic [WIDTH-1:0] data);
        return ^data;
    endfunction

    // Parity bit write port, in lockstep with the data array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            par_r[wr_addr] <= calc_parity(wr_data);
        end
    end

    // Parity check on read; the flag is only ever high in the cycle the read
    // data is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_perr_r <= 1'b0;
        end else if (rd_en) begin
            rd_perr_r <= (calc_parity(mem_r[rd_addr]) != par_r[rd_addr]);
        end else begin
            rd_perr_r <= 1'b0;
        end
    end

    assign rd_perr = rd_perr_r;
`else
    assign rd_perr = 1'b0;
`endif

endmodule : sram_storage

// File: rtl/sram_responder.sv
// SRAM responder: after reset, sweeps the array to zero one word per cycle,
// then serves single-cycle writes and latency-1 reads. Illegal accesses
// (we and oe together, out-of-range address, any access while clearing)
// are dropped and flagged with a one-cycle err pulse.
// Optional feature macro: SRAM_PARITY_EN (per-word even parity in storage).
module sram_responder
    import sram_pkg::*;
#(
    parameter int  WIDTH  = DEFAULT_WIDTH,
    parameter int  DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              we,
    input  logic              oe,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid,
    output logic              ready,
    output logic              err,
    output logic              parity_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    sram_state_t       state_r;
    sram_state_t       next_state_s;
    logic [ADDR_W-1:0] clr_ptr_r;
    logic [ADDR_W-1:0] clr_ptr_next_s;
    logic              ready_r;
    logic              rvalid_r;
    logic              err_r;

    logic              addr_ok_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [WIDTH-1:0]  wr_data_s;
    logic              rd_en_s;
    logic              reject_s;
    logic [WIDTH-1:0]  rd_data_s;
    logic              rd_perr_s;

    // With a power-of-two depth every address decodes to a real word.
    generate
        if (DEPTH == (1 << ADDR_W)) begin : g_addr_pow2
            assign addr_ok_s = 1'b1;
        end else begin : g_addr_range
            assign addr_ok_s = ({1'b0, addr} < DEPTH_EXT);
        end
    endgenerate

    // Next-state and access decode; reset suppresses every array access so a
    // write presented together with rst is discarded.
    always_comb begin
        next_state_s   = state_r;
        clr_ptr_next_s = clr_ptr_r;
        wr_en_s        = 1'b0;
        wr_addr_s      = addr;
        wr_data_s      = wdata;
        rd_en_s        = 1'b0;
        reject_s       = 1'b0;
        if (rst) begin
            next_state_s   = ST_CLEAR;
            clr_ptr_next_s = {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    wr_en_s   = 1'b1;
                    wr_addr_s = clr_ptr_r;
                    wr_data_s = {WIDTH{1'b0}};
                    reject_s  = cs;
                    if (clr_ptr_r == LAST_ADDR) begin
                        next_state_s   = ST_RUN;
                        clr_ptr_next_s = {ADDR_W{1'b0}};
                    end else begin
                        clr_ptr_next_s = clr_ptr_r + ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (cs) begin
                        if ((we && oe) || !addr_ok_s) begin
                            reject_s = 1'b1;
                        end else if (we) begin
                            wr_en_s = 1'b1;
                        end else if (oe) begin
                            rd_en_s = 1'b1;
                        end else begin
                            reject_s = 1'b0;
                        end
                    end else begin
                        reject_s = 1'b0;
                    end
                end
                default: begin
                    next_state_s   = ST_CLEAR;
                    clr_ptr_next_s = {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    // Controller state, clear pointer and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_CLEAR;
            clr_ptr_r <= {ADDR_W{1'b0}};
            ready_r   <= 1'b0;
            rvalid_r  <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            clr_ptr_r <= clr_ptr_next_s;
            ready_r   <= (next_state_s == ST_RUN);
            rvalid_r  <= rd_en_s;
            err_r     <= reject_s;
        end
    end

    sram_storage #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_storage (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s),
        .rd_en   (rd_en_s),
        .rd_addr (addr),
        .rd_data (rd_data_s),
        .rd_perr (rd_perr_s)
    );

    assign rdata      = rd_data_s;
    assign rvalid     = rvalid_r;
    assign ready      = ready_r;
    assign err        = err_r;
    assign parity_err = rd_perr_s;

endmodule : sram_responder

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder (default WIDTH=4, DEPTH=32).
// A behavioural model (plain array + edge counter) predicts every output
// after every clock edge.
module tb_sram_responder;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b0;
    logic       we = 1'b0;
    logic       oe = 1'b0;
    logic [4:0] addr = 5'd0;
    logic [3:0] wdata = 4'd0;
    logic [3:0] rdata;
    logic       rvalid;
    logic       ready;
    logic       err;
    logic       parity_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [3:0] m_mem [DEPTH];
    int         m_edges = 0;
    logic [3:0] exp_rdata = 4'd0;
    logic       exp_rvalid = 1'b0;
    logic       exp_ready = 1'b0;
    logic       exp_err = 1'b0;

    sram_responder dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .we         (we),
        .oe         (oe),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .ready      (ready),
        .err        (err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    // Model of one clock edge, from the access rules: clearing lasts DEPTH
    // edges after reset release; anything selected before that, or with both
    // enables, or out of range, is an error.
    task automatic model_edge(input logic i_cs, input logic i_we, input logic i_oe,
                              input logic [4:0] i_addr, input logic [3:0] i_wdata,
                              input logic i_rst);
        bit clearing;
        if (i_rst) begin
            m_edges    = 0;
            exp_rdata  = 4'd0;
            exp_rvalid = 1'b0;
            exp_err    = 1'b0;
            exp_ready  = 1'b0;
            for (int k = 0; k < DEPTH; k++) m_mem[k] = 4'd0;
        end else begin
            clearing   = (m_edges < DEPTH);
            m_edges++;
            exp_rvalid = 1'b0;
            exp_err    = 1'b0;
            if (i_cs) begin
                if (clearing || (i_we && i_oe) || (int'(i_addr) >= DEPTH)) begin
                    exp_err = 1'b1;
                end else if (i_we) begin
                    m_mem[i_addr] = i_wdata;
                end else if (i_oe) begin
                    exp_rdata  = m_mem[i_addr];
                    exp_rvalid = 1'b1;
                end
            end
            exp_ready = (m_edges >= DEPTH);
        end
    endtask

    task automatic cycle(input logic i_cs, input logic i_we, input logic i_oe,
                         input logic [4:0] i_addr, input logic [3:0] i_wdata,
                         input logic i_rst);
        cs    = i_cs;
        we    = i_we;
        oe    = i_oe;
        addr  = i_addr;
        wdata = i_wdata;
        rst   = i_rst;
        model_edge(i_cs, i_we, i_oe, i_addr, i_wdata, i_rst);
        @(posedge clk);
        #1;
        chk("rdata", 32'(rdata), 32'(exp_rdata));
        chk("rvalid", 32'(rvalid), 32'(exp_rvalid));
        chk("ready", 32'(ready), 32'(exp_ready));
        chk("err", 32'(err), 32'(exp_err));
        chk("parity_err", 32'(parity_err), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b0);
    endtask

    initial begin
        logic [3:0] rnd_data;
        logic [4:0] rnd_addr;

        // Reset state
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b1);

        // Clear sweep with an illegal access on the 10th edge
        idle(9);
        cycle(1'b1, 1'b1, 1'b0, 5'd7, 4'hF, 1'b0);
        chk("err_during_clear", 32'(err), 32'd1);
        idle(21);
        chk("ready_edge31_low", 32'(ready), 32'd0);
        idle(1);
        chk("ready_edge32_high", 32'(ready), 32'd1);
        idle(3);

        // Every word reads back zero
        for (int a = 0; a < DEPTH; a++) cycle(1'b1, 1'b0, 1'b1, 5'(a), 4'd0, 1'b0);
        idle(1);

        // Write then immediate read, then hold
        cycle(1'b1, 1'b1, 1'b0, 5'd5, 4'hA, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 5'd5, 4'd0, 1'b0);
        chk("wr_rd_same_addr", 32'(rdata), 32'hA);
        idle(3);
        chk("rdata_hold", 32'(rdata), 32'hA);

        // Protocol violation: we and oe together
        cycle(1'b1, 1'b1, 1'b0, 5'd3, 4'h6, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 5'd3, 4'hF, 1'b0);
        chk("viol_err", 32'(err), 32'd1);
        idle(1);
        chk("viol_err_one_cycle", 32'(err), 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 5'd3, 4'd0, 1'b0);
        chk("viol_no_write", 32'(rdata), 32'h6);

        // cs low ignores enables
        cycle(1'b0, 1'b1, 1'b0, 5'd3, 4'h1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 5'd3, 4'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 5'd3, 4'd0, 1'b0);

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            rnd_addr = 5'($urandom_range(0, DEPTH - 1));
            rnd_data = 4'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  rnd_addr, rnd_data, 1'b0);
        end

        // Reset during a write discards it; reset mid-clear restarts the sweep
        cycle(1'b1, 1'b1, 1'b0, 5'd9, 4'h5, 1'b1);
        idle(19);
        cycle(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 1'b1);
        chk("rst_midclear_ready", 32'(ready), 32'd0);
        idle(31);
        chk("restart_edge31_low", 32'(ready), 32'd0);
        idle(1);
        chk("restart_edge32_high", 32'(ready), 32'd1);
        cycle(1'b1, 1'b0, 1'b1, 5'd9, 4'd0, 1'b0);

        // Back-to-back writes of every address, then back-to-back reads
        for (int a = 0; a < DEPTH; a++) cycle(1'b1, 1'b1, 1'b0, 5'(a), 4'($urandom), 1'b0);
        for (int a = 0; a < DEPTH; a++) cycle(1'b1, 1'b0, 1'b1, 5'(a), 4'd0, 1'b0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_sram_responder

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of words.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port cs  in  1  chip select; we/oe ignored when low.
REQ-006 SHALL have port we  in  1  write enable.
REQ-007 SHALL have port oe  in  1  output enable (read).
REQ-008 SHALL have port addr  in  ADDR_W = $clog2(DEPTH)  word address.
REQ-009 SHALL have port wdata  in  WIDTH  write data.
REQ-010 SHALL have port rdata  out  WIDTH  registered read data; holds last read value.
REQ-011 SHALL have port rvalid  out  1  one-cycle pulse, rdata updated this cycle.
REQ-012 SHALL have port ready  out  1  high when array cleared and accepting accesses.
REQ-013 SHALL have port err  out  1  one-cycle registered pulse on rejected access.
REQ-014 SHALL have port parity_err  out  1  one-cycle pulse with rvalid on parity mismatch.

Function
REQ-015 SHALL implement FSM with states CLEAR and RUN; reset enters CLEAR.
REQ-016 SHALL, in CLEAR, write zero to one word per cycle at clear pointer 0..DEPTH-1, pointer incrementing by 1.
REQ-017 SHALL move CLEAR->RUN on the edge that clears word DEPTH-1; ready high exactly DEPTH edges after the first edge with rst low.
REQ-018 SHALL, in RUN with cs=1, we=1, oe=0, store wdata at mem[addr] on that edge; no rvalid.
REQ-019 SHALL, in RUN with cs=1, oe=1, we=0, load rdata from mem[addr] and pulse rvalid on the following cycle (latency 1).
REQ-020 SHALL support an access every cycle; write then read same addr on next cycle returns newly written data.
REQ-021 SHALL treat cs=1 with we=1 and oe=1 as a protocol violation: no write, no read, err pulses next cycle.
REQ-022 SHALL treat addr >= DEPTH (non-power-of-two DEPTH) with cs=1 as rejected: memory unchanged, no rvalid, err pulses.
REQ-023 SHALL, in CLEAR, ignore any cs=1 access and pulse err; mem contents governed only by clearing.
REQ-024 SHALL ignore we/oe when cs=0: no write, no rvalid, no err.
REQ-025 SHALL hold rdata unchanged whenever rvalid is low.

Reset
REQ-026 SHALL on rst=1 set state=CLEAR, clear pointer=0, rdata=0, rvalid=0, ready=0, err=0, parity_err=0.
REQ-027 SHALL, on rst asserted mid-clear or mid-access, abort and restart full CLEAR sequence; in-flight write discarded.

Configuration
REQ-028 SHALL, with SRAM_PARITY_EN defined, store an even-parity bit per word (cleared words store parity 0), check it on read, and pulse parity_err with rvalid on mismatch.
REQ-029 SHALL, without SRAM_PARITY_EN, store no parity bits and tie parity_err to 0; port list unchanged.

Structure
REQ-030 SHALL place the state enum (CLEAR, RUN) and default WIDTH/DEPTH constants in shared package sram_pkg.
REQ-031 SHALL isolate the word array plus optional parity bits in sub-module sram_storage (one write port, one registered read port).

Verification
REQ-032 SHALL test: release rst, idle -> ready=0 for 32 cycles, ready=1 from edge 32; read of every addr returns 0 with rvalid.
REQ-033 SHALL test: write addr=5 wdata=4'hA, next cycle read addr=5 -> rvalid next cycle, rdata=4'hA; rdata holds 4'hA afterwards.
REQ-034 SHALL test: cs=1 we=1 oe=1 addr=3 wdata=4'hF -> err one-cycle pulse, no rvalid, later read addr=3 returns previous value.
REQ-035 SHALL test: access with cs=1 during CLEAR (cycle 10) -> err pulse, ready stays 0, array reads 0 after ready.
REQ-036 SHALL test: rst pulsed mid-clear at cycle 20 -> ready=0, ready asserts 32 edges after rst release.
REQ-037 SHALL test, with SRAM_PARITY_EN: back-to-back writes then reads of all 32 addresses -> parity_err never asserts, data matches.
